mux_4x1_rr_arb: RTL and testbench
=================================

MUX_4X1_RR_ARB -- requirements
Module: mux_4x1_rr_arb

Interface
REQ-001 SHALL have parameter LEN, default 8, giving the data word width in bits.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port in_valid, input, 4 bits: bit i means the word on in<i> is offered.
REQ-005 SHALL have ports in0, in1, in2 and in3, each input, LEN bits: the candidate data words.
REQ-006 SHALL have port in_ready, output, 4 bits: one-hot acceptance; in<i> transfers when in_valid[i] and in_ready[i] are both high.
REQ-007 SHALL have port out, output, LEN bits: the registered selected word.
REQ-008 SHALL have port sel, output, 2 bits: the registered source index of the word on out.
REQ-009 SHALL have port out_valid, output, 1 bit: out and sel hold a word.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts the word when out_valid is also high.

Function
REQ-011 SHALL act as a 1-deep output buffer with two states:
 - EMPTY: out_valid=0.
 - FULL: out_valid=1.
REQ-012 SHALL compute can_load = (EMPTY) or (FULL and out_ready).
REQ-013 SHALL pick the grant round-robin:
 - Scan starts at ptr and runs ptr, ptr+1, ptr+2, ptr+3, all mod 4.
 - The first index with in_valid set wins.
 - With no in_valid bit set, there is no grant.
REQ-014 SHALL assert in_ready[g] only for the winning index g, and only when can_load is high and reset is low; all other bits stay 0.
REQ-015 SHALL, on a transfer from index g, do all of the following at the next edge:
 - out <= in<g>.
 - sel <= g.
 - out_valid <= 1.
 - ptr <= (g+1) mod 4; the increment wraps 3 -> 0.
REQ-016 SHALL clear out_valid at the next edge when FULL with out_ready high and no transfer; out and sel keep their last values.
REQ-017 SHALL, on simultaneous pop and push (FULL, out_ready=1, transfer), drop the old word, load the new word and stay FULL, giving one word per cycle sustained.
REQ-018 SHALL, when FULL with out_ready low, hold out, sel, out_valid and ptr stable and drive in_ready=0000.
REQ-019 SHALL leave ptr unchanged in any cycle without a transfer.
REQ-020 SHALL have an input-to-output latency of exactly 1 cycle from the transfer edge to out_valid.
REQ-021 SHALL implement in_ready as combinational from in_valid, ptr, out_valid, out_ready and reset, with no combinational path to out, sel or out_valid.
REQ-022 SHALL ignore input data on indices whose in_valid is low, including X values.

Reset
REQ-023 SHALL, on reset high at a clk edge, set out_valid=0, out=0, sel=0 and ptr=0.
REQ-024 SHALL drive in_ready=0000 while reset is high.
REQ-025 SHALL discard any buffered word on reset mid-operation; no transfer is recorded in that cycle.
REQ-026 SHALL grant from index 0 priority on the first post-reset cycle, because ptr=0.

Structure
REQ-027 SHALL take the constants NUM_IN=4 and SEL_W=2 from the shared package tabla_basic_pkg.
REQ-028 SHALL reuse mux_4x1 (LEN passed through) as its one sub-module, driven by the combinational grant index, to select the word loaded into out.
REQ-029 SHALL keep the round-robin picker inline: it is a combinational function of ptr and in_valid, not a separate module.

Verification
REQ-030 SHALL cover reset: with in_valid=1111 during reset, expect in_ready=0000; after reset drops, out_valid=0 and the first grant is index 0.
REQ-031 SHALL cover rotation: LEN=8, in0..in3=0x10,0x21,0x32,0x43, in_valid=1111, out_ready=1 for 6 cycles.
 - Expected sel sequence: 0,1,2,3,0,1.
 - Expected out sequence: 0x10,0x21,0x32,0x43,0x10,0x21.
 - out_valid stays high throughout.
REQ-032 SHALL cover sparse requests: in_valid=0100 then 0001 with ptr=3.
 - First grant is 2, then ptr=3.
 - Next grant is 0 (wrap); ptr becomes 1.
REQ-033 SHALL cover backpressure: FULL with sel=1 and out=0x21, out_ready=0 for 3 cycles.
 - out, sel and out_valid hold; in_ready=0000.
 - Releasing out_ready loads the next word in the same cycle.
REQ-034 SHALL cover drain: with a word held, in_valid=0000 and out_ready=1 gives out_valid=0 next cycle with sel unchanged.
REQ-035 SHALL cover mid-operation reset: reset asserted while FULL and in_valid=1111 gives out_valid=0, ptr=0 and out=0 the following cycle.

Source files
------------

// File: rtl/tabla_basic_pkg.sv
// Shared constants and helpers for the small 4-input arbitration/mux blocks.
package tabla_basic_pkg;

    localparam int unsigned NUM_IN = 4;
    localparam int unsigned SEL_W  = 2;

    // Next round-robin start index; wraps naturally at 2**SEL_W.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction

endpackage

// File: rtl/mux_4x1.sv
// Plain combinational 4:1 word selector.
module mux_4x1
    import tabla_basic_pkg::*;
#(
    parameter int unsigned LEN = 8
) (
    input  logic [LEN-1:0]   in0_i,
    input  logic [LEN-1:0]   in1_i,
    input  logic [LEN-1:0]   in2_i,
    input  logic [LEN-1:0]   in3_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [LEN-1:0]   out_o
);

    always_comb begin
        out_o = in0_i;
        unique case (sel_i)
            2'd0: out_o = in0_i;
            2'd1: out_o = in1_i;
            2'd2: out_o = in2_i;
            2'd3: out_o = in3_i;
            default: out_o = in0_i;
        endcase
    end

endmodule

// File: rtl/mux_4x1_rr_arb.sv
// Round-robin 4:1 arbiter feeding a 1-deep registered output buffer with valid/ready on both sides.
module mux_4x1_rr_arb
    import tabla_basic_pkg::*;
#(
    parameter int unsigned LEN = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_IN-1:0] in_valid,
    input  logic [LEN-1:0]    in0,
    input  logic [LEN-1:0]    in1,
    input  logic [LEN-1:0]    in2,
    input  logic [LEN-1:0]    in3,
    output logic [NUM_IN-1:0] in_ready,
    output logic [LEN-1:0]    out,
    output logic [SEL_W-1:0]  sel,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [LEN-1:0]   out_q, out_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] scan_idx;
    logic             grant_vld;
    logic             can_load;
    logic             xfer;
    logic [LEN-1:0]   mux_word;

    // First requester at or after ptr, wrapping modulo 4.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        scan_idx  = ptr_q;
        for (int k = 0; k < NUM_IN; k++) begin
            scan_idx = ptr_q + k[SEL_W-1:0];
            if (!grant_vld && in_valid[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    assign can_load = !out_valid_q || out_ready;

    always_comb begin
        in_ready = '0;
        if (grant_vld && can_load && !reset) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    assign xfer = |(in_ready & in_valid);

    mux_4x1 #(
        .LEN(LEN)
    ) u_mux (
        .in0_i(in0),
        .in1_i(in1),
        .in2_i(in2),
        .in3_i(in3),
        .sel_i(grant_idx),
        .out_o(mux_word)
    );

    always_comb begin
        out_d       = out_q;
        sel_d       = sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_d       = mux_word;
            sel_d       = grant_idx;
            out_valid_d = 1'b1;
            ptr_d       = wrap_inc(grant_idx);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            sel_q       <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_q       <= out_d;
            sel_q       <= sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out       = out_q;
    assign sel       = sel_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_4x1_rr_arb.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
module tb_mux_4x1_rr_arb;

    logic       clk;
    logic       reset;
    logic [3:0] in_valid;
    logic [7:0] in0, in1, in2, in3;
    logic [3:0] in_ready;
    logic [7:0] dout;
    logic [1:0] sel;
    logic       out_valid;
    logic       out_ready;

    int tests;
    int fails;

    // Behavioural model state
    int       m_ptr;
    bit       m_full;
    logic [7:0] m_out;
    int       m_sel;

    mux_4x1_rr_arb #(
        .LEN(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in0(in0),
        .in1(in1),
        .in2(in2),
        .in3(in3),
        .in_ready(in_ready),
        .out(dout),
        .sel(sel),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int p, input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4] === 1'b1) return (p + k) % 4;
        end
        return -1;
    endfunction

    // One clock cycle: drive inputs, check in_ready, clock, update model, check outputs.
    task automatic step(input logic r, input logic [3:0] iv, input logic ordy);
        int g;
        bit can;
        logic [7:0] data [4];
        logic [3:0] exp_rdy;
        reset     = r;
        in_valid  = iv;
        out_ready = ordy;
        #1;
        data[0] = in0;
        data[1] = in1;
        data[2] = in2;
        data[3] = in3;
        g   = pick(m_ptr, iv);
        can = !m_full || ordy;
        exp_rdy = 4'b0000;
        if (!r && g >= 0 && can) exp_rdy[g] = 1'b1;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (r) begin
            m_full = 0;
            m_out  = 8'h00;
            m_sel  = 0;
            m_ptr  = 0;
        end else if (g >= 0 && can) begin
            m_out  = data[g];
            m_sel  = g;
            m_full = 1;
            m_ptr  = (g + 1) % 4;
        end else if (m_full && ordy) begin
            m_full = 0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(m_full));
        chk("sel", 32'(sel), 32'(m_sel));
        chk("out", 32'(dout), 32'(m_out));
    endtask

    logic [1:0] rot_sel [6];
    logic [7:0] rot_out [6];
    logic [3:0] riv;

    initial begin
        tests = 0;
        fails = 0;
        m_ptr = 0; m_full = 0; m_out = 8'h00; m_sel = 0;
        reset = 1'b1; in_valid = 4'b0000; out_ready = 1'b0;
        in0 = 8'h10; in1 = 8'h21; in2 = 8'h32; in3 = 8'h43;
        rot_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rot_out = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h10, 8'h21};
        @(posedge clk);
        #1;

        // Reset with all requests pending: no grant, buffer empty.
        step(1'b1, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);

        // Rotation from ptr=0.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'b1111, 1'b1);
            chk("rot_sel", 32'(sel), 32'(rot_sel[i]));
            chk("rot_out", 32'(dout), 32'(rot_out[i]));
            chk("rot_valid", 32'(out_valid), 32'd1);
        end

        // Backpressure holding sel=1/out=0x21.
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b1111, 1'b0);
            chk("bp_sel", 32'(sel), 32'd1);
            chk("bp_out", 32'(dout), 32'h21);
            chk("bp_rdy", 32'(in_ready), 32'd0);
        end
        step(1'b0, 4'b1111, 1'b1);
        chk("bp_release_sel", 32'(sel), 32'd2);

        // Drain.
        step(1'b0, 4'b0000, 1'b1);
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_sel", 32'(sel), 32'd2);

        // Mid-operation reset while FULL.
        step(1'b0, 4'b1111, 1'b1);
        step(1'b1, 4'b1111, 1'b0);
        chk("midrst_out", 32'(dout), 32'd0);
        step(1'b0, 4'b1111, 1'b1);
        chk("post_rst_sel", 32'(sel), 32'd0);

        // Sparse requests with wrap; unrequested inputs carry X.
        step(1'b1, 4'b0000, 1'b1);
        in0 = 'x; in1 = 'x; in3 = 'x;
        step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0100, 1'b1);
        chk("sparse_sel2", 32'(sel), 32'd2);
        in0 = 8'h5a;
        step(1'b0, 4'b0001, 1'b1);
        chk("sparse_wrap_sel", 32'(sel), 32'd0);
        chk("sparse_wrap_out", 32'(dout), 32'h5a);
        in1 = 8'h21; in3 = 8'h43;
        step(1'b0, 4'b1111, 1'b1);
        chk("sparse_ptr1", 32'(sel), 32'd1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            riv = 4'($urandom_range(0, 15));
            in0 = riv[0] ? 8'($urandom) : 8'bx;
            in1 = riv[1] ? 8'($urandom) : 8'bx;
            in2 = riv[2] ? 8'($urandom) : 8'bx;
            in3 = riv[3] ? 8'($urandom) : 8'bx;
            step(($urandom_range(0, 39) == 0), riv, ($urandom_range(0, 3) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
